mem_arbiter: RTL and testbench

- Shares the single-port 64 KB byte memory between two requesters:
  - the CPU bus;
  - the text-mode video fetcher, which reads character/attribute bytes from B800-BFFF.
- Sequences one access at a time through a registered FSM and enforces write protection of the BIOS region (C000-FFFF).
- Bounds video starvation with a wait counter.
- Sits between the CPU / video scanout and the memory array, which has a 1-cycle registered read.

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared 64 KB byte memory: CPU bus and text-mode video fetch.
// One access in flight at a time; BIOS region is write-protected; video starvation is bounded.
module mem_arbiter #(
  parameter logic [15:0] VRAM_BASE    = 16'hB800,
  parameter logic [15:0] ROM_BASE     = 16'hC000,
  parameter int unsigned VID_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  input  logic        vid_req,
  input  logic [10:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_valid,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

  localparam logic [7:0] MaxWait = 8'(VID_MAX_WAIT);

  state_t      state;
  logic        owner_vid;  // 1 = current access belongs to the video fetcher
  logic        is_write;   // CPU write in flight (even if ROM-suppressed)
  logic [7:0]  vid_wait;
  logic        vid_win;
  logic        any_req;
  logic [15:0] vid_mem_addr;

  // Arbitration decision and video address translation
  always_comb begin
    vid_win      = vid_req && (!cpu_req || (vid_wait >= MaxWait));
    any_req      = cpu_req || vid_req;
    vid_mem_addr = VRAM_BASE + {5'b0, vid_addr};
  end

  assign busy = (state != StIdle);

  // Access sequencer with registered memory-side and requester-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      owner_vid <= 1'b0;
      is_write  <= 1'b0;
      vid_wait  <= 8'd0;
      mem_addr  <= 16'd0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'd0;
      cpu_rdata <= 8'd0;
      cpu_ready <= 1'b0;
      vid_rdata <= 8'd0;
      vid_valid <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          // A losing video request implies the CPU was granted this cycle
          if (!vid_req || vid_win) begin
            vid_wait <= 8'd0;
          end else if (vid_wait < MaxWait) begin
            vid_wait <= vid_wait + 8'd1;
          end
          if (any_req) begin
            state     <= StIssue;
            owner_vid <= vid_win;
            if (vid_win) begin
              mem_addr  <= vid_mem_addr;
              mem_we    <= 1'b0;
              mem_wdata <= 8'd0;
              is_write  <= 1'b0;
            end else begin
              mem_addr  <= cpu_addr;
              mem_we    <= cpu_we && (cpu_addr < ROM_BASE);
              mem_wdata <= cpu_wdata;
              is_write  <= cpu_we;
            end
          end
        end
        StIssue: begin
          mem_we <= 1'b0;
          if (is_write) begin
            cpu_ready <= 1'b1;
            state     <= StResp;
          end else begin
            state <= StWait;
          end
        end
        StWait: begin
          // Memory read data is valid this cycle (one after the address was sampled)
          if (owner_vid) begin
            vid_rdata <= mem_rdata;
            vid_valid <= 1'b1;
          end else begin
            cpu_rdata <= mem_rdata;
            cpu_ready <= 1'b1;
          end
          state <= StResp;
        end
        StResp: begin
          cpu_ready <= 1'b0;
          vid_valid <= 1'b0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, reference memory and response scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        vid_req;
  logic [10:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        vid_valid;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .VRAM_BASE   (16'hB800),
    .ROM_BASE    (16'hC000),
    .VID_MAX_WAIT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_rdata(vid_rdata),
    .vid_valid(vid_valid),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Power-on memory contents, shared by the memory model and the reference
  function automatic logic [7:0] init_val(input logic [15:0] a);
    case (a)
      16'h1234: return 8'h5A;
      16'hBFFF: return 8'h41;
      16'hC005: return 8'h77;
      default:  return a[7:0] ^ a[15:8];
    endcase
  endfunction

  logic [7:0] mem_arr [int];
  logic [7:0] ref_arr [int];

  function automatic logic [7:0] mem_peek(input logic [15:0] a);
    return mem_arr.exists(int'(a)) ? mem_arr[int'(a)] : init_val(a);
  endfunction

  function automatic logic [7:0] ref_peek(input logic [15:0] a);
    return ref_arr.exists(int'(a)) ? ref_arr[int'(a)] : init_val(a);
  endfunction

  // Single-port memory with 1-cycle registered read
  always @(posedge clk) begin
    mem_rdata <= mem_peek(mem_addr);
    if (mem_we) mem_arr[int'(mem_addr)] = mem_wdata;
  end

  typedef struct {
    logic       is_write;
    logic [7:0] data;
  } exp_t;

  exp_t       cpu_q [$];
  logic [7:0] vid_q [$];
  logic       glog [$];   // grant order observed from pulses, 1 = video
  exp_t       mon_e;
  logic [7:0] cpu_rd_m = 8'h00;

  // Response monitor: pop expected results as pulses appear
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_ready) begin
        glog.push_back(1'b0);
        check("cpu_q_nonempty", 32'(cpu_q.size() > 0), 32'd1);
        if (cpu_q.size() > 0) begin
          mon_e = cpu_q.pop_front();
          check(mon_e.is_write ? "cpu_rdata_kept_on_write" : "cpu_rdata", 32'(cpu_rdata),
                32'(mon_e.data));
        end
      end
      if (vid_valid) begin
        glog.push_back(1'b1);
        check("vid_q_nonempty", 32'(vid_q.size() > 0), 32'd1);
        if (vid_q.size() > 0) check("vid_rdata", 32'(vid_rdata), 32'(vid_q.pop_front()));
      end
    end
  end

  logic [15:0] addr_tr  [0:31];
  logic        we_tr    [0:31];
  logic        busy_tr  [0:31];
  logic [7:0]  wdata_tr [0:31];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input int c);
    addr_tr[c]  = mem_addr;
    we_tr[c]    = mem_we;
    busy_tr[c]  = busy;
    wdata_tr[c] = mem_wdata;
  endtask

  // Start optional CPU and video accesses in the current IDLE cycle (cycle 0); returns the
  // cycle of each completion pulse (-1 if none) and ends in the IDLE cycle after the last RESP.
  task automatic run(input logic c_en, input logic c_we, input logic [15:0] c_addr,
                     input logic [7:0] c_wd, input logic v_en, input logic [10:0] v_addr,
                     output int c_lat, output int v_lat);
    int c_cnt = 0;
    int v_cnt = 0;
    c_lat = -1;
    v_lat = -1;
    if (c_en) begin
      if (c_we) begin
        cpu_q.push_back('{is_write: 1'b1, data: cpu_rd_m});
        if (c_addr < 16'hC000) ref_arr[int'(c_addr)] = c_wd;
      end else begin
        cpu_rd_m = ref_peek(c_addr);
        cpu_q.push_back('{is_write: 1'b0, data: cpu_rd_m});
      end
    end
    if (v_en) vid_q.push_back(ref_peek(16'hB800 + {5'b0, v_addr}));
    cpu_req = c_en; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    vid_req = v_en; vid_addr = v_addr;
    record(0);
    for (int c = 1; c < 32; c++) begin
      step();
      record(c);
      if (cpu_ready) begin
        c_cnt++;
        if (c_lat < 0) c_lat = c;
        cpu_req = 1'b0;
      end
      if (vid_valid) begin
        v_cnt++;
        if (v_lat < 0) v_lat = c;
        vid_req = 1'b0;
      end
      if ((!c_en || c_lat >= 0) && (!v_en || v_lat >= 0)) break;
    end
    check("cpu_pulse_count", 32'(c_cnt), 32'(c_en));
    check("vid_pulse_count", 32'(v_cnt), 32'(v_en));
    step();
  endtask

  int cl, vl, pulses;
  logic [7:0] wait_m;
  logic       vwin;
  logic       exp_g [$];

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    vid_req = 1'b0; vid_addr = 11'h0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_vid_valid", 32'(vid_valid), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_vid_rdata", 32'(vid_rdata), 32'd0);
    step();

    // CPU read
    run(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 11'h0, cl, vl);
    check("rd_latency", 32'(cl), 32'd3);
    check("rd_mem_addr_c1", 32'(addr_tr[1]), 32'h1234);
    check("rd_mem_we", 32'(we_tr[0] | we_tr[1] | we_tr[2] | we_tr[3]), 32'd0);
    check("rd_busy_c0", 32'(busy_tr[0]), 32'd0);
    check("rd_busy_c1_3", 32'(busy_tr[1] & busy_tr[2] & busy_tr[3]), 32'd1);

    // CPU write then read back
    run(1'b1, 1'b1, 16'h0100, 8'hC3, 1'b0, 11'h0, cl, vl);
    check("wr_latency", 32'(cl), 32'd2);
    check("wr_mem_we_c1", 32'(we_tr[1]), 32'd1);
    check("wr_mem_wdata_c1", 32'(wdata_tr[1]), 32'hC3);
    check("wr_mem_we_c2", 32'(we_tr[2]), 32'd0);
    run(1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 11'h0, cl, vl);
    check("rdback_latency", 32'(cl), 32'd3);

    // Write into ROM region is suppressed but still completes
    run(1'b1, 1'b1, 16'hC005, 8'hFF, 1'b0, 11'h0, cl, vl);
    check("rom_wr_latency", 32'(cl), 32'd2);
    check("rom_wr_mem_we", 32'(we_tr[1] | we_tr[2]), 32'd0);
    check("rom_mem_unchanged", 32'(mem_peek(16'hC005)), 32'(ref_peek(16'hC005)));

    // Video read at top of VRAM
    run(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 11'h7FF, cl, vl);
    check("vid_latency", 32'(vl), 32'd3);
    check("vid_mem_addr_c1", 32'(addr_tr[1]), 32'hBFFF);

    // Simultaneous requests with no accumulated wait: CPU first, video right after
    run(1'b1, 1'b0, 16'h3456, 8'h00, 1'b1, 11'h123, cl, vl);
    check("sim_cpu_latency", 32'(cl), 32'd3);
    check("sim_vid_latency", 32'(vl), 32'd7);

    // Both requesters held continuously: starvation bound forces every fifth grant to video
    glog.delete();
    exp_g.delete();
    for (int i = 0; i < 8; i++) begin
      cpu_rd_m = ref_peek(16'h2000);
      cpu_q.push_back('{is_write: 1'b0, data: cpu_rd_m});
    end
    for (int i = 0; i < 2; i++) vid_q.push_back(ref_peek(16'hB810));
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
    vid_req = 1'b1; vid_addr = 11'h010;
    wait_m = 8'd0;
    pulses = 0;
    for (int c = 0; c < 80 && pulses < 10; c++) begin
      if (!busy) begin
        check("vid_wait", 32'(dut.vid_wait), 32'(wait_m));
        vwin = (wait_m >= 8'd4);
        exp_g.push_back(vwin);
        wait_m = vwin ? 8'd0 : wait_m + 8'd1;
      end
      step();
      if (cpu_ready || vid_valid) begin
        pulses++;
        if (pulses == 10) begin
          cpu_req = 1'b0;
          vid_req = 1'b0;
        end
      end
    end
    step();
    check("grant_count", 32'(glog.size()), 32'd10);
    for (int i = 0; i < exp_g.size() && i < glog.size(); i++) begin
      check($sformatf("grant_%0d", i), 32'(glog[i]), 32'(exp_g[i]));
    end

    // Reset during WAIT of a CPU read drops the access
    cpu_q.push_back('{is_write: 1'b0, data: ref_peek(16'h1234)});
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    step();
    step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_q.delete();
    step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("post_rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("post_rst_mem_addr", 32'(mem_addr), 32'd0);
    cpu_rd_m = 8'h00;
    rst = 1'b0;
    step();
    run(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 11'h0, cl, vl);
    check("reissue_latency", 32'(cl), 32'd3);

    repeat (2) step();
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("vid_q_drained", 32'(vid_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
